bus_arbiter: RTL
================

Name: bus_arbiter

Overview:
- Two-requester round-robin arbiter that shares one output channel, a single 2:1 data path, between two packet sources.
- Each source presents valid/last/data and receives ready. The winner holds the grant until its last beat is accepted.
- Output is registered: one pipeline stage with valid/ready backpressure.
- Sits in front of any shared consumer (bus, port, ALU input) that previously used a hard-wired select.

Parameters:
- data_width, 32, width of each data word.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous active-high reset.
- in0_valid  input  1  requester 0 presents a beat.
- in0_data  input  data_width  requester 0 beat data.
- in0_last  input  1  beat is final beat of requester 0 packet.
- in0_ready  output  1  requester 0 beat accepted this cycle when high with in0_valid.
- in1_valid, in1_data, in1_last, in1_ready  same as requester 0, for requester 1.
- out_valid  output  1  output register holds a beat.
- out_data  output  data_width  registered beat data.
- out_last  output  1  registered last flag.
- out_src  output  1  requester index that sourced the held beat.
- out_ready  input  1  consumer accepts the beat when high with out_valid.
- grant  output  2  one-hot current grant; 00 when idle.

Behaviour:
- FSM states: IDLE, GRANT0, GRANT1. grant = {state==GRANT1, state==GRANT0}.
- Reset (async, immediate):
  - state=IDLE, last_grant=1 (requester 0 wins the first tie).
  - out_valid=0, out_data=0, out_last=0, out_src=0.
  - in0_ready=in1_ready=0.
- Arbitration in IDLE; takes effect next cycle (one bubble):
  - Only inK_valid high -> GRANTK.
  - Both valid -> GRANT of ~last_grant.
  - Neither -> stay IDLE.
- Space is defined as (!out_valid || out_ready).
- inK_ready = (state==GRANTK) && space. This is combinational; inK_ready does not depend on inK_valid.
- Input transfer = inK_valid && inK_ready. On transfer: out_data<=inK_data, out_last<=inK_last, out_src<=K, out_valid<=1.
- Output consume with no transfer in the same cycle: out_valid<=0.
- Simultaneous consume and transfer: the register is overwritten with the new beat and out_valid stays 1. Full throughput is one beat per cycle.
- In GRANTK, on a transfer with inK_last=1:
  - last_grant<=K.
  - Other requester valid that cycle -> GRANT of other, with no bubble.
  - Otherwise -> IDLE.
- In GRANTK otherwise: stay GRANTK. The grant is never revoked mid-packet, however long the packet is.
- A granted requester that deasserts valid mid-packet keeps the grant (bubble). The other requester waits.
- Latency: beat on input at cycle n appears on out_* at n+1.
- Packets are never interleaved. All out_src values between two out_last beats are equal.
- No data loss or duplication under any out_ready pattern. out_* are held stable while out_valid && !out_ready.
- A non-granted requester's valid/data are ignored. Its ready is 0.
- Single-beat packets (last on first beat) are legal.
- Reset mid-packet: the packet is truncated and the held beat discarded. There is no recovery or resume; a requester re-presents from IDLE.

Test Plan:
- Single source: reset; in0 sends 3 beats A1,A2,A3(last), out_ready=1. Required:
  - grant=01 one cycle after in0_valid.
  - out_data A1,A2,A3 on consecutive cycles with out_src=0; out_last only on A3.
  - grant returns to 00.
- Tie after reset: in0 and in1 both valid, single-beat packets X0 and Y1 held continuously. Required: X0 granted first, then Y1 with no bubble between grants, then X0 again (alternation 0,1,0,1).
- Back-to-back rotation: in1 sends a 4-beat packet while in0 raises valid on beat 2. Required:
  - in0_ready=0 until in1 last accepted.
  - grant switches 10->01 in the cycle after last; no IDLE cycle.
  - last_grant=1.
- Backpressure: in0 streams 5 beats 0x10..0x14 with out_ready pattern 1,0,0,1,1,0,1,1,1. Required:
  - out_data stable while stalled.
  - in0_ready=0 during stalls.
  - Received sequence exactly 0x10..0x14 with no gaps or duplicates.
- Mid-packet idle source: in0 sends beat 1, drops valid 3 cycles, then sends the last beat; in1 valid throughout. Required: grant stays 01 for the whole gap; in1 is served only after in0 last.
- Reset mid-packet: assert reset asynchronously between clock edges during in1 beat 2 of 4. Required:
  - out_valid=0, grant=00 and in0/in1_ready=0 immediately.
  - After release with both valid, requester 0 wins (last_grant reset to 1).

Source files
------------

// File: rtl/bus_arbiter.sv
// Two-requester round-robin packet arbiter feeding one registered output stage.
// The winner keeps the grant until its last beat is accepted.
module bus_arbiter #(
  parameter int unsigned data_width = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in0_valid,
  input  logic [data_width-1:0] in0_data,
  input  logic                  in0_last,
  output logic                  in0_ready,
  input  logic                  in1_valid,
  input  logic [data_width-1:0] in1_data,
  input  logic                  in1_last,
  output logic                  in1_ready,
  output logic                  out_valid,
  output logic [data_width-1:0] out_data,
  output logic                  out_last,
  output logic                  out_src,
  input  logic                  out_ready,
  output logic [1:0]            grant
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  state_t state;
  state_t state_next;
  logic   last_grant;
  logic   last_grant_next;
  logic   space;
  logic   take0;
  logic   take1;

  // Output register can take a beat when empty or being drained this cycle.
  assign space = !out_valid || out_ready;
  assign take0 = in0_valid && in0_ready;
  assign take1 = in1_valid && in1_ready;

  // State register; last_grant=1 lets requester 0 win the first tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
    end else begin
      state      <= state_next;
      last_grant <= last_grant_next;
    end
  end

  // Next state: arbitrate from IDLE, hand over without a bubble on last beat.
  always_comb begin
    state_next      = state;
    last_grant_next = last_grant;
    case (state)
      IDLE: begin
        if (in0_valid && in1_valid) state_next = last_grant ? GRANT0 : GRANT1;
        else if (in0_valid)         state_next = GRANT0;
        else if (in1_valid)         state_next = GRANT1;
      end
      GRANT0: begin
        if (take0 && in0_last) begin
          last_grant_next = 1'b0;
          state_next      = in1_valid ? GRANT1 : IDLE;
        end
      end
      GRANT1: begin
        if (take1 && in1_last) begin
          last_grant_next = 1'b1;
          state_next      = in0_valid ? GRANT0 : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs decoded from state; ready is independent of the requester's valid.
  always_comb begin
    grant     = {state == GRANT1, state == GRANT0};
    in0_ready = (state == GRANT0) && space;
    in1_ready = (state == GRANT1) && space;
  end

  // Output pipeline stage; a transfer overwrites a beat being consumed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_src   <= 1'b0;
    end else if (take0) begin
      out_valid <= 1'b1;
      out_data  <= in0_data;
      out_last  <= in0_last;
      out_src   <= 1'b0;
    end else if (take1) begin
      out_valid <= 1'b1;
      out_data  <= in1_data;
      out_last  <= in1_last;
      out_src   <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
